// File: rtl/des_key_scheduler.sv
// DES key schedule: accepts a 64-bit key, applies PC-1, then streams the 16
// PC-2 round subkeys over a valid/ready handshake in encrypt or decrypt order.
module des_key_scheduler #(
    parameter bit PARITY_CHECK = 1'b1,
    parameter int ROUND_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [63:0]        key,
    input  logic               mode,
    input  logic               restart,
    output logic               key_err,
    output logic               key_loaded,
    output logic               sk_valid,
    input  logic               sk_ready,
    output logic [47:0]        sk,
    output logic [ROUND_W-1:0] sk_round,
    output logic               sk_last
);

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state;
    logic        mode_q;
    logic [55:0] key_pc1;
    logic [55:0] pc1_q;
    logic [55:0] cd_q;
    logic [55:0] start_src;
    logic [55:0] start_cd;
    logic [55:0] adv_cd;
    logic [47:0] sk_start;
    logic [47:0] sk_adv;
    logic [7:0]  byte_par;
    logic        parity_ok;
    logic        adv_single;

    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic single);
        return single ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic single);
        return single ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // Fixed wiring permutations; key[0] carries FIPS bit 64, which PC-1 never uses.
    for (genvar p = 0; p < 56; p++) begin : g_pc1
        assign key_pc1[55-p] = key[PC1_TAB[p]];
    end

    for (genvar q = 0; q < 48; q++) begin : g_pc2
        assign sk_start[47-q] = start_cd[56-PC2_TAB[q]];
        assign sk_adv[47-q]   = adv_cd[56-PC2_TAB[q]];
    end

    for (genvar j = 0; j < 8; j++) begin : g_par
        assign byte_par[j] = ^{key[8*j+7 : 8*j+1], key[(8*j+8) % 64]};
    end

    assign parity_ok = &byte_par;

    always_comb begin
        start_src = key_valid ? key_pc1 : pc1_q;
        start_cd  = mode ? start_src
                         : {rot_l(start_src[55:28], 1'b1), rot_l(start_src[27:0], 1'b1)};
        // Single-bit steps fall on rounds 1, 2, 9 and 16 of the schedule.
        if (mode_q)
            adv_single = (sk_round == ROUND_W'(0)) || (sk_round == ROUND_W'(1)) ||
                         (sk_round == ROUND_W'(8)) || (sk_round == ROUND_W'(15));
        else
            adv_single = (sk_round == ROUND_W'(0)) || (sk_round == ROUND_W'(7)) ||
                         (sk_round == ROUND_W'(14));
        adv_cd = mode_q ? {rot_r(cd_q[55:28], adv_single), rot_r(cd_q[27:0], adv_single)}
                        : {rot_l(cd_q[55:28], adv_single), rot_l(cd_q[27:0], adv_single)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            key_ready  <= 1'b1;
            key_err    <= 1'b0;
            key_loaded <= 1'b0;
            sk_valid   <= 1'b0;
            sk         <= '0;
            sk_round   <= '0;
            sk_last    <= 1'b0;
            mode_q     <= 1'b0;
            pc1_q      <= '0;
            cd_q       <= '0;
        end else begin
            key_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_valid && PARITY_CHECK && !parity_ok) begin
                        key_err    <= 1'b1;
                        key_loaded <= 1'b0;
                    end else if (key_valid || (restart && key_loaded)) begin
                        if (key_valid) begin
                            pc1_q      <= key_pc1;
                            key_loaded <= 1'b1;
                        end
                        state     <= S_RUN;
                        key_ready <= 1'b0;
                        sk_valid  <= 1'b1;
                        mode_q    <= mode;
                        cd_q      <= start_cd;
                        sk        <= sk_start;
                        sk_round  <= mode ? ROUND_W'(15) : ROUND_W'(0);
                        sk_last   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (sk_ready) begin
                        if (sk_last) begin
                            state     <= S_IDLE;
                            key_ready <= 1'b1;
                            sk_valid  <= 1'b0;
                            sk_last   <= 1'b0;
                        end else begin
                            cd_q     <= adv_cd;
                            sk       <= sk_adv;
                            sk_round <= mode_q ? sk_round - ROUND_W'(1) : sk_round + ROUND_W'(1);
                            sk_last  <= mode_q ? (sk_round == ROUND_W'(1)) : (sk_round == ROUND_W'(14));
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    key_ready <= 1'b1;
                    sk_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: a FIPS-level key schedule model
// checked every valid cycle, plus literal subkeys from the standard example.
module tb_des_key_scheduler;

    localparam logic [63:0] GOOD_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] BAD_KEY  = 64'h133457799BBCDFF0;
    localparam logic [47:0] K1_LIT   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_LIT   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16_LIT  = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key;
    logic        mode;
    logic        restart;
    logic        key_err;
    logic        key_loaded;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] sk;
    logic [3:0]  sk_round;
    logic        sk_last;

    logic        np_key_ready;
    logic        np_key_err;
    logic        np_key_loaded;
    logic        np_sk_valid;
    logic [47:0] np_sk;
    logic [3:0]  np_sk_round;
    logic        np_sk_last;

    logic [47:0] ks [16];
    bit          run_expected;
    bit          exp_mode;
    int          pos;
    int          hs_count;
    int          total;
    int          bad;

    des_key_scheduler #(.PARITY_CHECK(1'b1), .ROUND_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .key(key), .mode(mode), .restart(restart), .key_err(key_err),
        .key_loaded(key_loaded), .sk_valid(sk_valid), .sk_ready(sk_ready),
        .sk(sk), .sk_round(sk_round), .sk_last(sk_last)
    );

    des_key_scheduler #(.PARITY_CHECK(1'b0), .ROUND_W(4)) dut_np (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(np_key_ready),
        .key(key), .mode(mode), .restart(restart), .key_err(np_key_err),
        .key_loaded(np_key_loaded), .sk_valid(np_sk_valid), .sk_ready(sk_ready),
        .sk(np_sk), .sk_round(np_sk_round), .sk_last(np_sk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Textbook schedule: subkey r uses C0/D0 rotated by the cumulative shift count.
    task automatic buildModel(input logic [63:0] kf);
        logic fb [65];
        int   cum;
        int   k;
        fb[0] = 1'b0;
        for (int n = 1; n <= 64; n++) fb[n] = kf[64-n];
        cum = 0;
        for (int r = 0; r < 16; r++) begin
            cum += SHIFTS[r];
            for (int q = 0; q < 48; q++) begin
                k = PC2_T[q] - 1;
                if (k < 28) ks[r][47-q] = fb[PC1_T[(k + cum) % 28]];
                else        ks[r][47-q] = fb[PC1_T[28 + (k - 28 + cum) % 28]];
            end
        end
    endtask

    function automatic logic [63:0] toPort(input logic [63:0] kf);
        logic [63:0] p;
        for (int n = 1; n <= 63; n++) p[n] = kf[64-n];
        p[0] = kf[0];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic kv, input logic rs, input logic md,
                                 input logic [63:0] kf);
        key_valid = kv;
        restart   = rs;
        mode      = md;
        key       = toPort(kf);
    endtask

    task automatic expectRun(input bit md);
        exp_mode     = md;
        pos          = 0;
        hs_count     = 0;
        run_expected = 1'b1;
    endtask

    task automatic waitIdle(input int budget, input string name);
        for (int i = 0; i < budget && !key_ready; i++) tick();
        checkOutput(name, 64'(key_ready), 64'd1);
    endtask

    // Every valid cycle is checked against the model; a handshake advances it.
    always @(negedge clk) begin
        if (rst_n && sk_valid) begin
            if (!run_expected) begin
                checkOutput("sk_valid_unexpected", 64'(sk_valid), 64'd0);
            end else begin
                automatic int rnd = exp_mode ? 15 - pos : pos;
                checkOutput("cmp_sk", 64'(sk), 64'(ks[rnd]));
                checkOutput("cmp_sk_round", 64'(sk_round), 64'(rnd));
                checkOutput("cmp_sk_last", 64'(sk_last), 64'(pos == 15));
                checkOutput("cmp_key_ready_run", 64'(key_ready), 64'd0);
                if (sk_ready) begin
                    pos++;
                    hs_count++;
                    if (pos == 16) run_expected = 1'b0;
                end
            end
        end
    end

    initial begin
        total        = 0;
        bad          = 0;
        run_expected = 1'b0;
        exp_mode     = 1'b0;
        pos          = 0;
        hs_count     = 0;
        sk_ready     = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_key_ready", 64'(key_ready), 64'd1);
        checkOutput("rst_sk_valid", 64'(sk_valid), 64'd0);
        checkOutput("rst_key_err", 64'(key_err), 64'd0);
        checkOutput("rst_key_loaded", 64'(key_loaded), 64'd0);
        checkOutput("rst_sk", 64'(sk), 64'd0);
        checkOutput("rst_sk_round", 64'(sk_round), 64'd0);
        checkOutput("rst_sk_last", 64'(sk_last), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        buildModel(GOOD_KEY);
        checkOutput("model_k1", 64'(ks[0]), 64'(K1_LIT));
        checkOutput("model_k2", 64'(ks[1]), 64'(K2_LIT));
        checkOutput("model_k16", 64'(ks[15]), 64'(K16_LIT));

        // Encrypt order, sk_ready held high.
        sk_ready = 1'b1;
        expectRun(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, GOOD_KEY);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, GOOD_KEY);
        checkOutput("enc_k1", 64'(sk), 64'(K1_LIT));
        checkOutput("enc_k1_valid", 64'(sk_valid), 64'd1);
        checkOutput("enc_key_loaded", 64'(key_loaded), 64'd1);
        tick();
        checkOutput("enc_k2", 64'(sk), 64'(K2_LIT));
        repeat (14) tick();
        checkOutput("enc_k16", 64'(sk), 64'(K16_LIT));
        checkOutput("enc_k16_last", 64'(sk_last), 64'd1);
        checkOutput("enc_k16_round", 64'(sk_round), 64'd15);
        tick();
        checkOutput("enc_key_ready_end", 64'(key_ready), 64'd1);
        checkOutput("enc_sk_valid_end", 64'(sk_valid), 64'd0);
        checkOutput("enc_handshakes", 64'(hs_count), 64'd16);

        // Decrypt replay of the stored key.
        expectRun(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, GOOD_KEY);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, GOOD_KEY);
        checkOutput("dec_first_sk", 64'(sk), 64'(K16_LIT));
        checkOutput("dec_first_round", 64'(sk_round), 64'd15);
        repeat (15) tick();
        checkOutput("dec_last_sk", 64'(sk), 64'(K1_LIT));
        checkOutput("dec_last_round", 64'(sk_round), 64'd0);
        checkOutput("dec_last_flag", 64'(sk_last), 64'd1);
        tick();
        checkOutput("dec_key_ready_end", 64'(key_ready), 64'd1);
        checkOutput("dec_handshakes", 64'(hs_count), 64'd16);

        // Random backpressure with stray key_valid/restart pulses during RUN.
        expectRun(1'b0);
        sk_ready = 1'(($urandom_range(0, 1)));
        applyStimulus(1'b1, 1'b0, 1'b0, GOOD_KEY);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, GOOD_KEY);
        for (int i = 0; i < 400 && !key_ready; i++) begin
            sk_ready = 1'(($urandom_range(0, 1)));
            applyStimulus(1'(($urandom_range(0, 3) == 0)), 1'(($urandom_range(0, 3) == 0)),
                          1'b1, BAD_KEY);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, GOOD_KEY);
        sk_ready = 1'b1;
        checkOutput("bp_key_ready_end", 64'(key_ready), 64'd1);
        checkOutput("bp_handshakes", 64'(hs_count), 64'd16);

        // Parity reject; the parity-blind instance accepts the same key.
        applyStimulus(1'b1, 1'b0, 1'b0, BAD_KEY);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, GOOD_KEY);
        checkOutput("par_key_err", 64'(key_err), 64'd1);
        checkOutput("par_key_loaded", 64'(key_loaded), 64'd0);
        checkOutput("par_key_ready", 64'(key_ready), 64'd1);
        checkOutput("np_sk_valid", 64'(np_sk_valid), 64'd1);
        checkOutput("np_k1", 64'(np_sk), 64'(K1_LIT));
        checkOutput("np_sk_round", 64'(np_sk_round), 64'd0);
        checkOutput("np_sk_last", 64'(np_sk_last), 64'd0);
        checkOutput("np_key_err", 64'(np_key_err), 64'd0);
        checkOutput("np_key_loaded", 64'(np_key_loaded), 64'd1);
        tick();
        checkOutput("par_key_err_pulse", 64'(key_err), 64'd0);
        for (int i = 0; i < 40 && !np_key_ready; i++) tick();
        checkOutput("np_key_ready_end", 64'(np_key_ready), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, GOOD_KEY);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, GOOD_KEY);
        checkOutput("par_restart_ignored", 64'(sk_valid), 64'd0);
        checkOutput("par_restart_ready", 64'(key_ready), 64'd1);
        tick();
        checkOutput("par_restart_ignored2", 64'(sk_valid), 64'd0);

        // Reset after the fifth handshake aborts the run.
        waitIdle(40, "rst_pre_idle");
        expectRun(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, GOOD_KEY);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, GOOD_KEY);
        repeat (5) tick();
        rst_n        = 1'b0;
        run_expected = 1'b0;
        #1;
        checkOutput("midrst_handshakes", 64'(hs_count), 64'd5);
        checkOutput("midrst_sk_valid", 64'(sk_valid), 64'd0);
        checkOutput("midrst_key_loaded", 64'(key_loaded), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("midrst_key_ready", 64'(key_ready), 64'd1);
        checkOutput("midrst_key_loaded2", 64'(key_loaded), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, GOOD_KEY);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, GOOD_KEY);
        checkOutput("midrst_restart_ignored", 64'(sk_valid), 64'd0);
        tick();
        checkOutput("midrst_restart_ignored2", 64'(sk_valid), 64'd0);
        checkOutput("midrst_idle_ready", 64'(key_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
